// File: rtl/onewire_pkg.sv
// Shared types for the open-drain single-wire bus master.
// Op encodings, FSM states and a width helper.
package onewire_pkg;

  typedef enum logic [1:0] {
    OP_RST = 2'b00,
    OP_WR  = 2'b01,
    OP_RD  = 2'b10,
    OP_NOP = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_LOW,
    S_RST_WAIT,
    S_SLOT_LOW,
    S_SLOT_HOLD,
    S_REC,
    S_DONE
  } state_e;

  function automatic int max_of(
    input int a, input int b, input int c, input int d,
    input int e, input int f, input int g
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    if (f > m) m = f;
    if (g > m) m = g;
    return m;
  endfunction

endpackage

// File: rtl/onewire_od_master_if.sv
// Command/response handshake between the byte-level
// controller and the bit-level bus master.
interface onewire_od_master_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       cmd_bit;
  logic       rsp_valid;
  logic       rsp_bit;

  modport master (
    output cmd_valid, cmd_op, cmd_bit,
    input  cmd_ready, rsp_valid, rsp_bit
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_bit,
    output cmd_ready, rsp_valid, rsp_bit
  );

endinterface

// File: rtl/od_us_timer.sv
// Microsecond timebase: prescaler plus elapsed-us counter,
// both restarted by clr_i so state timing is clock-exact.
module od_us_timer #(
  parameter int CLK_DIV = 50,
  parameter int CW      = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  output logic          tick_o,
  output logic [CW-1:0] us_o
);

  localparam int PW = $clog2(CLK_DIV);

  logic [PW-1:0] pre_q, pre_d;
  logic [CW-1:0] us_q, us_d;

  assign tick_o = (pre_q == PW'(CLK_DIV - 1));
  assign us_o   = us_q;

  // next prescaler / us value; clear wins over tick
  always_comb begin
    pre_d = pre_q + 1'b1;
    us_d  = us_q;
    if (clr_i) begin
      pre_d = '0;
      us_d  = '0;
    end else if (tick_o) begin
      pre_d = '0;
      us_d  = us_q + 1'b1;
    end
  end

  // timer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      us_q  <= '0;
    end else begin
      pre_q <= pre_d;
      us_q  <= us_d;
    end
  end

endmodule

// File: rtl/onewire_od_master.sv
// Open-drain single-wire bus master: reset/presence,
// write-bit and read-bit slots, one command at a time.
module onewire_od_master
  import onewire_pkg::*;
#(
  parameter int CLK_DIV   = 50,
  parameter int T_RST_US  = 480,
  parameter int T_PRS_US  = 70,
  parameter int T_SLOT_US = 60,
  parameter int T_LOW1_US = 6,
  parameter int T_SMP_US  = 15,
  parameter int T_REC_US  = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  onewire_od_master_if.slave   bus,
  output logic                 presence,
  output logic                 busy,
  output logic                 dq_oe,
  input  logic                 dq_in
);

  localparam int TMAX = max_of(T_RST_US, T_PRS_US,
    T_SLOT_US, T_LOW1_US, T_SMP_US, T_REC_US, 1);
  localparam int CW = $clog2(TMAX + 1);

  state_e        state_q, state_d;
  op_e           op_q;
  logic          bit_q;
  logic          sync1_q, sync2_q;
  logic          rsp_bit_q, prs_q;
  logic          tmr_clr, tick;
  logic [CW-1:0] us;
  logic          accept, short_low;
  logic          hit_rst, hit_prs, hit_slot;
  logic          hit_low1, hit_smp, hit_rec;

  od_us_timer #(
    .CLK_DIV (CLK_DIV),
    .CW      (CW)
  ) u_tmr (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (tmr_clr),
    .tick_o (tick),
    .us_o   (us)
  );

  // a hit fires on the last clock before us reaches N,
  // so a state lasting N us spans exactly N*CLK_DIV clocks
  assign hit_rst  = tick && (us == CW'(T_RST_US - 1));
  assign hit_prs  = tick && (us == CW'(T_PRS_US - 1));
  assign hit_slot = tick && (us == CW'(T_SLOT_US - 1));
  assign hit_low1 = tick && (us == CW'(T_LOW1_US - 1));
  assign hit_smp  = tick && (us == CW'(T_SMP_US - 1));
  assign hit_rec  = tick && (us == CW'(T_REC_US - 1));

  assign accept    = bus.cmd_valid && (state_q == S_IDLE);
  assign short_low = (op_q == OP_RD) ||
                     ((op_q == OP_WR) && bit_q);

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_DONE);
  assign bus.rsp_bit   = rsp_bit_q;
  assign presence      = prs_q;
  assign busy          = (state_q != S_IDLE);
  assign dq_oe         = (state_q == S_RST_LOW) ||
                         (state_q == S_SLOT_LOW);

  // next state and timer restart; slot time spans LOW+HOLD
  always_comb begin
    state_d = state_q;
    tmr_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op_e'(bus.cmd_op))
            OP_RST:  state_d = S_RST_LOW;
            OP_WR:   state_d = S_SLOT_LOW;
            OP_RD:   state_d = S_SLOT_LOW;
            default: state_d = S_DONE;
          endcase
        end
      end
      S_RST_LOW:  if (hit_rst) state_d = S_RST_WAIT;
      S_RST_WAIT: if (hit_rst) state_d = S_DONE;
      S_SLOT_LOW: begin
        if (short_low && hit_low1)
          state_d = S_SLOT_HOLD;
        else if (!short_low && hit_slot)
          state_d = S_REC;
      end
      S_SLOT_HOLD: if (hit_slot) state_d = S_REC;
      S_REC:       if (hit_rec) state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    tmr_clr = (state_q == S_IDLE) ||
              ((state_d != state_q) &&
               !((state_q == S_SLOT_LOW) &&
                 (state_d == S_SLOT_HOLD)));
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // line synchroniser, command latch and sample registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      op_q      <= OP_RST;
      bit_q     <= 1'b0;
      rsp_bit_q <= 1'b0;
      prs_q     <= 1'b0;
    end else begin
      sync1_q <= dq_in;
      sync2_q <= sync1_q;
      if (accept) begin
        op_q      <= op_e'(bus.cmd_op);
        bit_q     <= bus.cmd_bit;
        rsp_bit_q <= (op_e'(bus.cmd_op) == OP_NOP) ?
                     1'b1 : bus.cmd_bit;
      end
      if ((state_q == S_RST_WAIT) && hit_prs) begin
        rsp_bit_q <= sync2_q;
        prs_q     <= ~sync2_q;
      end
      if ((state_q == S_SLOT_HOLD) &&
          (op_q == OP_RD) && hit_smp)
        rsp_bit_q <= sync2_q;
    end
  end

endmodule

// File: tb/tb_onewire_od_master.sv
// Scoreboard bench for onewire_od_master (CLK_DIV=4)
// with a wired-AND slave/pullup model on dq_in.
module tb_onewire_od_master;

  typedef struct {
    logic rsp;
    logic prs;
    int   lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic presence, busy, dq_oe, dq_in;
  logic slave_low;
  int   mode = 0;

  onewire_od_master_if bus ();

  onewire_od_master #(.CLK_DIV(4)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .presence (presence),
    .busy     (busy),
    .dq_oe    (dq_oe),
    .dq_in    (dq_in)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   low_q[$];
  int   pass_n = 0;
  int   tot_n  = 0;
  int   rsp_n  = 0;
  int   acc_n  = 0;
  int   oe_n   = 0;
  int   lat    = 0;
  int   run    = 0;

  // slave model: t0 counts from master pull-down, t1 from release
  int   t0 = 100000;
  int   t1 = 100000;
  logic oe_d = 1'b0;

  always @(posedge clk) begin
    if (dq_oe && !oe_d) t0 <= 0;
    else                t0 <= t0 + 1;
    if (!dq_oe && oe_d) t1 <= 0;
    else                t1 <= t1 + 1;
    oe_d <= dq_oe;
  end

  // mode 1: presence pulse 15..135 us after reset release
  // mode 2: hold line low 0..30 us from slot start
  assign slave_low = ((mode == 1) && (t1 >= 60) && (t1 < 540)) ||
                     ((mode == 2) && (t0 < 120));
  assign dq_in = ~(dq_oe | slave_low);

  task automatic chk(input string nm, input int act, input int exp);
    tot_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  nm, act, exp, $time);
  endtask

  // monitor: latency, response scoreboard, dq_oe low-run lengths
  always @(negedge clk) begin
    exp_t e;
    lat++;
    if (bus.rsp_valid) begin
      rsp_n++;
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_bit", int'(bus.rsp_bit), int'(e.rsp));
        chk("presence", int'(presence), int'(e.prs));
        chk("latency", lat, e.lat);
      end
    end
    if (bus.cmd_valid && bus.cmd_ready && !rst) begin
      acc_n++;
      lat = 0;
    end
    if (dq_oe) begin
      run++;
      oe_n++;
    end else if (run > 0) begin
      if (low_q.size() == 0) chk("low_unexpected", 1, 0);
      else chk("low_len", run, low_q.pop_front());
      run = 0;
    end
  end

  task automatic issue(input logic [1:0] op, input logic b,
                       input logic rsp, input logic prs,
                       input int lat_e, input int low_e);
    @(posedge clk); #1;
    for (int i = 0; i < 100 && !bus.cmd_ready; i++) begin
      @(posedge clk); #1;
    end
    exp_q.push_back('{rsp, prs, lat_e});
    if (low_e > 0) low_q.push_back(low_e);
    bus.cmd_op    = op;
    bus.cmd_bit   = b;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    for (int k = 0; k < 6000 && rsp_n < target; k++)
      @(negedge clk);
    chk("rsp_count", rsp_n, target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int o0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_bit   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", int'(bus.cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_oe", int'(dq_oe), 0);
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_presence", int'(presence), 0);
    chk("rst_rsp_bit", int'(bus.rsp_bit), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // reset with slave present
    mode = 1;
    issue(2'b00, 1'b0, 1'b0, 1'b1, 3841, 1920);
    wait_rsp(1);
    mode = 0;
    // write-1, write-0: presence survives
    issue(2'b01, 1'b1, 1'b1, 1'b1, 281, 24);
    wait_rsp(2);
    issue(2'b01, 1'b0, 1'b0, 1'b1, 281, 240);
    wait_rsp(3);
    // read with slave holding low, then silent
    mode = 2;
    issue(2'b10, 1'b0, 1'b0, 1'b1, 281, 24);
    wait_rsp(4);
    mode = 0;
    issue(2'b10, 1'b0, 1'b1, 1'b1, 281, 24);
    wait_rsp(5);
    // reset with no slave overwrites presence
    issue(2'b00, 1'b0, 1'b1, 1'b0, 3841, 1920);
    wait_rsp(6);

    // cmd_valid held through a whole write-1 slot
    @(posedge clk); #1;
    a0 = acc_n;
    exp_q.push_back('{1'b1, 1'b0, 281});
    low_q.push_back(24);
    bus.cmd_op    = 2'b01;
    bus.cmd_bit   = 1'b1;
    bus.cmd_valid = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    wait_rsp(7);
    chk("held_accepts", acc_n - a0, 1);

    // op 11 held for 10 clocks: accept every other clock
    @(posedge clk); #1;
    a0 = acc_n;
    o0 = oe_n;
    for (int i = 0; i < 5; i++)
      exp_q.push_back('{1'b1, 1'b0, 1});
    bus.cmd_op    = 2'b11;
    bus.cmd_bit   = 1'b0;
    bus.cmd_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    wait_rsp(12);
    chk("nop_accepts", acc_n - a0, 5);
    chk("nop_no_oe", oe_n - o0, 0);

    // rst at slot time 3 us of a write-0
    @(posedge clk); #1;
    low_q.push_back(12);
    bus.cmd_op    = 2'b01;
    bus.cmd_bit   = 1'b0;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_oe", int'(dq_oe), 0);
    chk("abort_ready", int'(bus.cmd_ready), 1);
    chk("abort_rsp_valid", int'(bus.rsp_valid), 0);
    chk("abort_busy", int'(busy), 0);
    rst = 1'b0;

    repeat (20) @(posedge clk);
    chk("exp_q_left", exp_q.size(), 0);
    chk("low_q_left", low_q.size(), 0);
    chk("rsp_total", rsp_n, 12);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
